layered_color_mapper: RTL
=========================

LAYERED_COLOR_MAPPER -- requirements
Module: layered_color_mapper

Interface
REQ-001 Parameters SHALL be: NUM_BULLETS, default 4, number of bullet channels (1..8).
REQ-002 Parameters SHALL be: BULLET_LEN, default 4, bullet height in lines.
REQ-003 Parameters SHALL be: BULLET_W, default 1, bullet width in pixels.
REQ-004 Parameters SHALL be: FLASH_FRAMES, default 60, hit-flash duration in frames.
REQ-005 Parameters SHALL be: FLASH_PERIOD, default 4, frames per blink half-period.
REQ-006 Ports SHALL be:
- Clk  in  1  pixel clock; single clock domain.
- Reset_n  in  1  asynchronous, active-low reset.
- pixel_valid  in  1  DrawX/DrawY are in the visible region this cycle.
- DrawX, DrawY  in  10 each  current pixel.
- frame_start  in  1  one-cycle pulse per frame.
- bullet_active  in  NUM_BULLETS  per-channel enable.
- bulletX, bulletY  in  NUM_BULLETS x 10 each  bullet top-left.
- player_on  in  1  player sprite pixel opaque.
- player_color  in  24  {R,G,B}.
- enemy_on  in  1  enemy sprite pixel opaque.
- enemy_color  in  24  {R,G,B}.
- bg_R, bg_G, bg_B  in  8 each  background.
- hit_pulse  in  1  player was hit; starts the flash.
- Red, Green, Blue  out  8 each  registered pixel colour.
- out_valid  out  1  Red/Green/Blue correspond to a valid input pixel.
- flashing  out  1  flash sequence in progress.

Function
REQ-007 A bullet hit for channel i SHALL be bullet_active[i] && bulletX[i] <= DrawX < bulletX[i]+BULLET_W && bulletY[i] <= DrawY < bulletY[i]+BULLET_LEN, with the sums computed at 11 bits so that no wrap occurs.
REQ-008 Layer priority SHALL be: any bullet (FFFFFF) > player (player_color, unless hidden) > enemy (enemy_color) > background.
REQ-009 The pipeline SHALL be 2 stages: stage 1 registers the hit flags and candidate colours; stage 2 registers the selected RGB. Output latency SHALL be exactly 2 cycles from inputs to Red/Green/Blue.
REQ-010 out_valid SHALL equal pixel_valid delayed 2 cycles. When out_valid=0, RGB SHALL be 000000.
REQ-011 The flash FSM SHALL have two states, IDLE and FLASH. In IDLE, hit_pulse SHALL load frame_cnt=FLASH_FRAMES and phase_cnt=0, clear hidden, and transition to FLASH.
REQ-012 In FLASH, each frame_start SHALL decrement frame_cnt and increment phase_cnt. When phase_cnt reaches FLASH_PERIOD-1, the next frame_start SHALL toggle hidden and reset phase_cnt to 0.
REQ-013 In FLASH, when frame_start arrives with frame_cnt==1, the FSM SHALL return to IDLE with hidden=0.
REQ-014 hit_pulse received in FLASH SHALL reload frame_cnt=FLASH_FRAMES and keep the current phase (restart, no stacking).
REQ-015 If hit_pulse and frame_start occur in the same cycle, hit_pulse SHALL win: the counter is reloaded and there is no decrement.
REQ-016 While hidden=1, player_on SHALL be ignored, so the pixel falls through to enemy or background.
REQ-017 The hidden flag SHALL change only on a frame_start edge, so the player image never tears mid-frame.
REQ-018 flashing SHALL be 1 exactly while the state is FLASH.

Reset
REQ-019 Asserting Reset_n low SHALL asynchronously clear all pipeline registers, Red/Green/Blue=0, out_valid=0, state=IDLE, frame_cnt=0, phase_cnt=0, hidden=0, flashing=0.
REQ-020 Reset asserted mid-flash SHALL abort the flash. After deassertion, the first valid output SHALL appear 2 cycles after the first pixel_valid.

Structure
REQ-021 Package sprite_pkg SHALL hold rgb_t (packed R,G,B bytes), the flash_state_t enum {IDLE, FLASH}, and the localparam WHITE=24'hFFFFFF.
REQ-022 The flash FSM and counters SHALL live in sub-module flash_timer (ports: Clk, Reset_n, frame_start, hit_pulse, hidden, flashing). Bullet hit detection SHALL be a generate loop in the top level.

Verification
REQ-023 Bullet at X=100, Y=200, NUM_BULLETS=4, BULLET_LEN=4: DrawX=100 with DrawY=199/200/203/204 -> bg/FFFFFF/FFFFFF/bg, each appearing 2 cycles later.
REQ-024 Priority test: bullet, player and enemy all on at one pixel -> FFFFFF. Player and enemy on (player_color=00FF00) -> 00FF00. Enemy alone (FF0000) -> FF0000.
REQ-025 Flash test: hit_pulse, then 60 frame_start pulses with FLASH_PERIOD=4 -> hidden toggles after frames 4, 8, ...; flashing drops on the 60th frame_start; player visible afterwards.
REQ-026 Boundary test: hit_pulse coincident with frame_start at frame 30 of a flash -> frame_cnt reloads to 60; the flash ends 60 frame_starts later.
REQ-027 Reset test: assert Reset_n during FLASH with pixel_valid streaming -> outputs 0 immediately, flashing=0; first nonzero out_valid occurs 2 cycles after release.
REQ-028 Wrap test: bulletY=1022, DrawY=0..3 -> no bullet hit (no 10-bit wrap).

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite colour pipeline.
package sprite_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FLASH = 1'b1
   } flash_state_t;

   localparam logic [23:0] WHITE = 24'hFFFFFF;

endpackage

// File: rtl/flash_timer.sv
// Hit-flash sequencer: counts frames after a hit and blinks the player by
// toggling hidden on frame boundaries only.
module flash_timer
   import sprite_pkg::*;
#(
   parameter int FLASH_FRAMES = 60,
   parameter int FLASH_PERIOD = 4
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic frame_start,
   input  logic hit_pulse,
   output logic hidden,
   output logic flashing
);

   localparam int FW = $clog2(FLASH_FRAMES + 1);
   localparam int PW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

   flash_state_t   state_reg, state_next;
   logic [FW-1:0]  frame_cnt_reg, frame_cnt_next;
   logic [PW-1:0]  phase_cnt_reg, phase_cnt_next;
   logic           hidden_reg, hidden_next;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg     <= IDLE;
         frame_cnt_reg <= '0;
         phase_cnt_reg <= '0;
         hidden_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         frame_cnt_reg <= frame_cnt_next;
         phase_cnt_reg <= phase_cnt_next;
         hidden_reg    <= hidden_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      frame_cnt_next = frame_cnt_reg;
      phase_cnt_next = phase_cnt_reg;
      hidden_next    = hidden_reg;
      case (state_reg)
         IDLE: begin
            if (hit_pulse) begin
               state_next     = FLASH;
               frame_cnt_next = FW'(FLASH_FRAMES);
               phase_cnt_next = '0;
               hidden_next    = 1'b0;
            end
         end
         FLASH: begin
            // A new hit restarts the duration but keeps the blink rhythm.
            if (hit_pulse) begin
               frame_cnt_next = FW'(FLASH_FRAMES);
            end else if (frame_start) begin
               if (frame_cnt_reg == FW'(1)) begin
                  state_next     = IDLE;
                  frame_cnt_next = '0;
                  phase_cnt_next = '0;
                  hidden_next    = 1'b0;
               end else begin
                  frame_cnt_next = frame_cnt_reg - FW'(1);
                  if (phase_cnt_reg == PW'(FLASH_PERIOD - 1)) begin
                     phase_cnt_next = '0;
                     hidden_next    = ~hidden_reg;
                  end else begin
                     phase_cnt_next = phase_cnt_reg + PW'(1);
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign hidden   = hidden_reg;
   assign flashing = (state_reg == FLASH);

endmodule

// File: rtl/layered_color_mapper.sv
// Two-stage pixel compositor: bullets over player over enemy over background,
// with the player blinked out during a hit flash.
module layered_color_mapper
   import sprite_pkg::*;
#(
   parameter int NUM_BULLETS  = 4,
   parameter int BULLET_LEN   = 4,
   parameter int BULLET_W     = 1,
   parameter int FLASH_FRAMES = 60,
   parameter int FLASH_PERIOD = 4
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      pixel_valid,
   input  logic [9:0]                DrawX,
   input  logic [9:0]                DrawY,
   input  logic                      frame_start,
   input  logic [NUM_BULLETS-1:0]    bullet_active,
   input  logic [NUM_BULLETS*10-1:0] bulletX,
   input  logic [NUM_BULLETS*10-1:0] bulletY,
   input  logic                      player_on,
   input  logic [23:0]               player_color,
   input  logic                      enemy_on,
   input  logic [23:0]               enemy_color,
   input  logic [7:0]                bg_R,
   input  logic [7:0]                bg_G,
   input  logic [7:0]                bg_B,
   input  logic                      hit_pulse,
   output logic [7:0]                Red,
   output logic [7:0]                Green,
   output logic [7:0]                Blue,
   output logic                      out_valid,
   output logic                      flashing
);

   logic                   hidden;
   logic [NUM_BULLETS-1:0] bullet_hit;

   flash_timer #(
      .FLASH_FRAMES (FLASH_FRAMES),
      .FLASH_PERIOD (FLASH_PERIOD)
   ) u_flash_timer (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .frame_start (frame_start),
      .hit_pulse   (hit_pulse),
      .hidden      (hidden),
      .flashing    (flashing)
   );

   // Bounds are compared at 11 bits so a bullet near 1023 cannot wrap to row 0.
   generate
      for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_bullet
         logic [10:0] bx, by, px, py;
         assign bx = {1'b0, bulletX[gi*10 +: 10]};
         assign by = {1'b0, bulletY[gi*10 +: 10]};
         assign px = {1'b0, DrawX};
         assign py = {1'b0, DrawY};
         assign bullet_hit[gi] = bullet_active[gi]
                              && (px >= bx) && (px < bx + 11'(BULLET_W))
                              && (py >= by) && (py < by + 11'(BULLET_LEN));
      end
   endgenerate

   logic s1_valid_reg, s1_bullet_reg, s1_player_reg, s1_enemy_reg;
   rgb_t s1_player_c_reg, s1_enemy_c_reg, s1_bg_reg;
   rgb_t rgb_reg, rgb_next;
   logic out_valid_reg;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_valid_reg    <= 1'b0;
         s1_bullet_reg   <= 1'b0;
         s1_player_reg   <= 1'b0;
         s1_enemy_reg    <= 1'b0;
         s1_player_c_reg <= '0;
         s1_enemy_c_reg  <= '0;
         s1_bg_reg       <= '0;
      end else begin
         s1_valid_reg    <= pixel_valid;
         s1_bullet_reg   <= |bullet_hit;
         s1_player_reg   <= player_on && !hidden;
         s1_enemy_reg    <= enemy_on;
         s1_player_c_reg <= player_color;
         s1_enemy_c_reg  <= enemy_color;
         s1_bg_reg       <= '{r: bg_R, g: bg_G, b: bg_B};
      end
   end

   always_comb begin
      rgb_next = '0;
      if (s1_valid_reg) begin
         if (s1_bullet_reg)      rgb_next = WHITE;
         else if (s1_player_reg) rgb_next = s1_player_c_reg;
         else if (s1_enemy_reg)  rgb_next = s1_enemy_c_reg;
         else                    rgb_next = s1_bg_reg;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rgb_reg       <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         rgb_reg       <= rgb_next;
         out_valid_reg <= s1_valid_reg;
      end
   end

   assign Red       = rgb_reg.r;
   assign Green     = rgb_reg.g;
   assign Blue      = rgb_reg.b;
   assign out_valid = out_valid_reg;

endmodule
